// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//
// Definitions shared by the MIPS pipeline blocks.
//
// Contents:
//   WORD_W         architectural word width (32)
//   multu_state_t  state encoding of the iterative unsigned multiplier
//                  (IDLE, RUN, DONE)
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } multu_state_t;

endpackage

// File: rtl/multu_seq_if.sv
// ---------------------------------------------------------------------------
// multu_seq_if
//
// Bundle between the EX stage / write-back path (master) and the iterative
// multiply sequencer (slave).
//
// Signals:
//   multu_enE  master->slave  multiply issue request from EX
//   flushE     master->slave  pipeline flush, aborts a multiply in flight
//   op_aE      master->slave  multiplicand (rs value)
//   op_bE      master->slave  multiplier (rt value)
//   stall      slave->master  freezes PC, IF/ID and ID/EX
//   busy       slave->master  sequencer is not idle
//   hilo_we    slave->master  one-cycle HI/LO write strobe
//   HI_d       slave->master  product upper word
//   LO_d       slave->master  product lower word
// ---------------------------------------------------------------------------
interface multu_seq_if
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W
);

    logic             multu_enE;
    logic             flushE;
    logic [WIDTH-1:0] op_aE;
    logic [WIDTH-1:0] op_bE;
    logic             stall;
    logic             busy;
    logic             hilo_we;
    logic [WIDTH-1:0] HI_d;
    logic [WIDTH-1:0] LO_d;

    // Pipeline side: issues the operation and consumes the result.
    modport master (
        output multu_enE,
        output flushE,
        output op_aE,
        output op_bE,
        input  stall,
        input  busy,
        input  hilo_we,
        input  HI_d,
        input  LO_d
    );

    // Multiplier side.
    modport slave (
        input  multu_enE,
        input  flushE,
        input  op_aE,
        input  op_bE,
        output stall,
        output busy,
        output hilo_we,
        output HI_d,
        output LO_d
    );

endinterface

// File: rtl/multu_step.sv
// ---------------------------------------------------------------------------
// multu_step
//
// One radix-2 shift-add iteration, purely combinational.
//
// Ports:
//   acc          in   running partial product (2*WIDTH)
//   mcand        in   shifted multiplicand (2*WIDTH)
//   mplier       in   remaining multiplier bits (WIDTH)
//   acc_next     out  acc, plus mcand when the current multiplier bit is set
//   mcand_next   out  mcand shifted left by one
//   mplier_next  out  mplier shifted right by one
//   mplier_zero  out  no multiplier bits remain after this step
// ---------------------------------------------------------------------------
module multu_step
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [2*WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0]   mplier_next,
    output logic               mplier_zero
);

    // The product of two WIDTH-bit operands always fits in 2*WIDTH bits,
    // so the accumulation never needs a carry out.
    always_comb begin
        acc_next    = mplier[0] ? (acc + mcand) : acc;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        mplier_zero = (mplier_next == '0);
    end

endmodule

// File: rtl/multu_seq.sv
// ---------------------------------------------------------------------------
// multu_seq
//
// Iterative WIDTH x WIDTH unsigned multiply sequencer for the MIPS pipeline.
// Accepts a multu issue from EX, runs one multiplier bit per cycle while
// stalling the front end, then presents the product on HI_d/LO_d with a
// one-cycle hilo_we strobe.
//
// Parameters:
//   WIDTH  operand width (product is 2*WIDTH)
//   CNT_W  iteration counter width, $clog2(WIDTH)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    multu_seq_if.slave: issue/flush/operands in,
//          stall/busy/hilo_we/HI_d/LO_d out
//
// Build option:
//   MULTU_EARLY_EXIT_EN  when defined, RUN also ends as soon as no multiplier
//                        bits remain; otherwise RUN is always WIDTH cycles.
// ---------------------------------------------------------------------------
module multu_seq
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    multu_seq_if.slave bus
);

    localparam int               PROD_W   = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    multu_state_t      state;
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] mcand;
    logic [WIDTH-1:0]  mplier;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic              hilo_we_q;
    logic              busy_q;

    logic [PROD_W-1:0] acc_next;
    logic [PROD_W-1:0] mcand_next;
    logic [WIDTH-1:0]  mplier_next;
    logic              mplier_zero;
    logic              start;
    logic              last_iter;

    // A flush in the same cycle as an issue wins, so no start happens.
    assign start = bus.multu_enE && !bus.flushE;

    multu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (acc_next),
        .mcand_next  (mcand_next),
        .mplier_next (mplier_next),
        .mplier_zero (mplier_zero)
    );

`ifdef MULTU_EARLY_EXIT_EN
    // Once the shifted multiplier is empty the accumulator is already final.
    assign last_iter = (cnt == LAST_CNT) || mplier_zero;
`else
    // Fixed-length run; the zero flag has no consumer in this build.
    logic unused_mplier_zero;
    assign unused_mplier_zero = mplier_zero;
    assign last_iter          = (cnt == LAST_CNT);
`endif

    // Stall covers the issue cycle itself (combinational on the request)
    // and every RUN cycle, but not DONE, so the pipeline resumes as the
    // product is written back.
    assign bus.stall   = (state == RUN) || ((state == IDLE) && start);
    assign bus.busy    = busy_q;
    assign bus.hilo_we = hilo_we_q;
    assign bus.HI_d    = hi_q;
    assign bus.LO_d    = lo_q;

    // Sequencer FSM with datapath, counter and registered outputs.
    // HI_d/LO_d load from acc_next on the final RUN edge so the product is
    // valid in the same cycle the strobe is high, and they hold until the
    // next completion (a flush leaves them untouched).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            hilo_we_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hilo_we_q <= 1'b0;
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, bus.op_aE};
                        mplier <= bus.op_bE;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end

                RUN: begin
                    if (bus.flushE) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand_next;
                        mplier <= mplier_next;
                        cnt    <= cnt + CNT_W'(1);
                        if (last_iter) begin
                            hi_q      <= acc_next[PROD_W-1:WIDTH];
                            lo_q      <= acc_next[WIDTH-1:0];
                            hilo_we_q <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                DONE: begin
                    hilo_we_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    hilo_we_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multu_seq.sv
// ---------------------------------------------------------------------------
// tb_multu_seq
//
// Directed bench for multu_seq: reset state, basic and maximum products,
// flush in RUN and in IDLE, asynchronous reset mid-RUN, re-issue while busy,
// and (with MULTU_EARLY_EXIT_EN) early-exit latency.
// ---------------------------------------------------------------------------
module tb_multu_seq;

    logic clk;
    logic rst_n;

    int checks;
    int fails;

    multu_seq_if #(.WIDTH(32)) bus_if ();

    multu_seq #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle in which hilo_we is expected, counting the issue cycle as 0.
    // This also equals the number of stalled cycles.
    function automatic int expWe(input logic [31:0] b);
        int msb;
        msb = 0;
`ifdef MULTU_EARLY_EXIT_EN
        for (int i = 0; i < 32; i++) begin
            if (b[i]) msb = i;
        end
        return msb + 2;
`else
        msb = 31;
        return msb + 2;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one multiply at the current time (cycle 0) and follows it until
    // the sequencer is back in IDLE or the cycle budget runs out. A flush or
    // re-issue pulse can be injected in a given cycle (-1 for none).
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input int flushAt, input int reissueAt,
                                 output int weCycle, output int stallCnt,
                                 output int weCount, output int endCycle);
        weCycle  = -1;
        stallCnt = 0;
        weCount  = 0;
        endCycle = -1;
        bus_if.op_aE     = a;
        bus_if.op_bE     = b;
        bus_if.flushE    = 1'b0;
        bus_if.multu_enE = 1'b1;
        #1;
        if (bus_if.stall) stallCnt++;
        for (int cyc = 1; cyc < 80; cyc++) begin
            @(posedge clk);
            #1;
            bus_if.multu_enE = (cyc == reissueAt);
            bus_if.flushE    = (cyc == flushAt);
            if (cyc == reissueAt) begin
                bus_if.op_aE = 32'h0000_0001;
                bus_if.op_bE = 32'h0000_0001;
            end
            #1;
            if (bus_if.stall) stallCnt++;
            if (bus_if.hilo_we) begin
                weCount++;
                if (weCycle < 0) weCycle = cyc;
            end
            if (!bus_if.busy) begin
                endCycle = cyc;
                break;
            end
        end
        bus_if.multu_enE = 1'b0;
        bus_if.flushE    = 1'b0;
    endtask

    initial begin
        int weC;
        int stC;
        int weN;
        int endC;

        checks = 0;
        fails  = 0;
        rst_n            = 1'b0;
        bus_if.multu_enE = 1'b0;
        bus_if.flushE    = 1'b0;
        bus_if.op_aE     = '0;
        bus_if.op_bE     = '0;

        // Reset state
        #2;
        checkOutput("reset_stall",   64'(bus_if.stall),   64'd0);
        checkOutput("reset_busy",    64'(bus_if.busy),    64'd0);
        checkOutput("reset_hilo_we", 64'(bus_if.hilo_we), 64'd0);
        checkOutput("reset_HI",      64'(bus_if.HI_d),    64'd0);
        checkOutput("reset_LO",      64'(bus_if.LO_d),    64'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] basic product 3*5");
        applyStimulus(32'h0000_0003, 32'h0000_0005, -1, -1, weC, stC, weN, endC);
        checkOutput("basic_we_cycle", 64'(weC), 64'(expWe(32'h0000_0005)));
        checkOutput("basic_stall_cnt", 64'(stC), 64'(expWe(32'h0000_0005)));
        checkOutput("basic_we_count", 64'(weN), 64'd1);
        checkOutput("basic_HI", 64'(bus_if.HI_d), 64'h0000_0000);
        checkOutput("basic_LO", 64'(bus_if.LO_d), 64'h0000_000F);

        $display("[TB] maximum operands");
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, weC, stC, weN, endC);
        checkOutput("max_we_cycle", 64'(weC), 64'd33);
        checkOutput("max_HI", 64'(bus_if.HI_d), 64'hFFFF_FFFE);
        checkOutput("max_LO", 64'(bus_if.LO_d), 64'h0000_0001);

        $display("[TB] flush in RUN at cycle 10");
        applyStimulus(32'h0000_0007, 32'hFFFF_FFFF, 10, -1, weC, stC, weN, endC);
        checkOutput("flush_idle_cycle", 64'(endC), 64'd11);
        checkOutput("flush_we_count", 64'(weN), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("flush_no_we", 64'(bus_if.hilo_we), 64'd0);
        end
        checkOutput("flush_HI_kept", 64'(bus_if.HI_d), 64'hFFFF_FFFE);
        checkOutput("flush_LO_kept", 64'(bus_if.LO_d), 64'h0000_0001);

        $display("[TB] flush overrides issue in IDLE");
        bus_if.op_aE     = 32'h0000_0009;
        bus_if.op_bE     = 32'h0000_0009;
        bus_if.multu_enE = 1'b1;
        bus_if.flushE    = 1'b1;
        #1;
        checkOutput("idle_flush_stall", 64'(bus_if.stall), 64'd0);
        @(posedge clk);
        #1;
        bus_if.multu_enE = 1'b0;
        bus_if.flushE    = 1'b0;
        checkOutput("idle_flush_busy", 64'(bus_if.busy), 64'd0);

        $display("[TB] asynchronous reset mid-RUN");
        bus_if.op_aE     = 32'h0000_0011;
        bus_if.op_bE     = 32'hFFFF_FFFF;
        bus_if.multu_enE = 1'b1;
        @(posedge clk);
        #1;
        bus_if.multu_enE = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_stall",   64'(bus_if.stall),   64'd0);
        checkOutput("areset_busy",    64'(bus_if.busy),    64'd0);
        checkOutput("areset_hilo_we", 64'(bus_if.hilo_we), 64'd0);
        checkOutput("areset_HI",      64'(bus_if.HI_d),    64'd0);
        checkOutput("areset_LO",      64'(bus_if.LO_d),    64'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(32'h0000_1234, 32'h0000_0010, -1, -1, weC, stC, weN, endC);
        checkOutput("after_reset_we_cycle", 64'(weC), 64'(expWe(32'h0000_0010)));
        checkOutput("after_reset_HI", 64'(bus_if.HI_d), 64'h0000_0000);
        checkOutput("after_reset_LO", 64'(bus_if.LO_d), 64'h0001_2340);

        $display("[TB] re-issue while busy at cycle 5");
        applyStimulus(32'h0000_ABCD, 32'h0000_1357, -1, 5, weC, stC, weN, endC);
        checkOutput("reissue_we_cycle", 64'(weC), 64'(expWe(32'h0000_1357)));
        checkOutput("reissue_we_count", 64'(weN), 64'd1);
        checkOutput("reissue_HI", 64'(bus_if.HI_d), 64'h0000_0000);
        checkOutput("reissue_LO", 64'(bus_if.LO_d), 64'h0CFA_99AB);
        checkOutput("reissue_next_issue_cycle", 64'(endC), 64'(expWe(32'h0000_1357) + 1));
        applyStimulus(32'h0000_0002, 32'h0000_0003, -1, -1, weC, stC, weN, endC);
        checkOutput("back_to_back_stall_cnt", 64'(stC), 64'(expWe(32'h0000_0003)));
        checkOutput("back_to_back_LO", 64'(bus_if.LO_d), 64'h0000_0006);

`ifdef MULTU_EARLY_EXIT_EN
        $display("[TB] early exit");
        applyStimulus(32'h1234_5678, 32'h0000_0010, -1, -1, weC, stC, weN, endC);
        checkOutput("early_we_cycle", 64'(weC), 64'd6);
        checkOutput("early_HI", 64'(bus_if.HI_d), 64'h0000_0001);
        checkOutput("early_LO", 64'(bus_if.LO_d), 64'h2345_6780);
        applyStimulus(32'h1234_5678, 32'h0000_0000, -1, -1, weC, stC, weN, endC);
        checkOutput("early_zero_we_cycle", 64'(weC), 64'd2);
        checkOutput("early_zero_HI", 64'(bus_if.HI_d), 64'h0000_0000);
        checkOutput("early_zero_LO", 64'(bus_if.LO_d), 64'h0000_0000);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/multu_seq.md
# multu_seq

Iterative 32×32 unsigned multiply sequencer for the five-stage MIPS pipeline. It accepts a `multu` issue from the EX stage and runs a radix-2 shift-add over the shared HI/LO result path. While the multiply runs, it stalls the front end of the pipeline. It then presents the 64-bit product with a one-cycle HI/LO write strobe that the write-back path forwards into the HI/LO registers.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. The product is `2*WIDTH`.
- `CNT_W`, default 5: iteration counter width, equal to `$clog2(WIDTH)`.

Ports:
- `clk` input 1: single clock. Everything is sampled on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `multu_enE` input 1: multiply issue request from the EX stage.
- `flushE` input 1: pipeline flush. Aborts any multiply in flight.
- `op_aE` input WIDTH: multiplicand (rs value).
- `op_bE` input WIDTH: multiplier (rt value).
- `stall` output 1: freezes the PC, IF/ID and ID/EX registers.
- `busy` output 1: high when the FSM is not in IDLE.
- `hilo_we` output 1: one-cycle HI/LO write strobe.
- `HI_d` output WIDTH: product bits [63:32].
- `LO_d` output WIDTH: product bits [31:0].

## Operation
- FSM states: IDLE, RUN, DONE. Encoding comes from the shared package.
- **IDLE**
  - When `multu_enE` is high and `flushE` is low, the block latches:
    - `mcand` = zero-extended `op_aE` (64 bit)
    - `mplier` = `op_bE`
    - `acc` = 0
    - `cnt` = 0
  - It then moves to RUN.
- **RUN**, one multiplier bit per cycle:
  - If `mplier[0]`, then `acc` ← `acc` + `mcand`. The addition is modulo 2^64 and can never overflow.
  - `mcand` ← `mcand` << 1.
  - `mplier` ← `mplier` >> 1.
  - `cnt` ← `cnt` + 1.
  - Exit to DONE after the cycle with `cnt` == WIDTH-1, which makes 32 RUN cycles. On that edge, `HI_d` and `LO_d` are loaded with the final `acc` value.
- **DONE**
  - `hilo_we` is high for exactly this one cycle.
  - Next state is IDLE, unconditionally.
  - A `multu_enE` arriving in DONE is ignored. Pipeline interlock guarantees none arrives.
- **`stall`** is combinational and high when either:
  - the state is RUN, or
  - the state is IDLE with `multu_enE` high and `flushE` low.
- **`busy`** is registered: high in RUN and in DONE.
- **`flushE`**
  - In RUN: the next state is IDLE. `hilo_we` is not asserted and `HI_d`/`LO_d` keep their previous values.
  - In IDLE: the flush overrides `multu_enE`, so no start happens.
- `multu_enE` arriving while in RUN is ignored and does not restart the operation.
- `HI_d` and `LO_d` hold the last completed product until the next completion.

## Timing
- **Reset** (`rst_n` low, asynchronous): state = IDLE, and `acc`, `mcand`, `mplier`, `cnt`, `HI_d`, `LO_d`, `hilo_we`, `busy` all = 0. The `stall` output follows its combinational equation.
- **Reset mid-RUN**: the operation is abandoned immediately and no write strobe is issued.
- **Latency** without the configuration macro:
  - Issue edge at cycle 0.
  - RUN occupies cycles 1–32.
  - `hilo_we` is high in cycle 33, with valid `HI_d`/`LO_d`.
  - `stall` is high for cycles 0–32, 33 cycles in total.
- **Back-to-back**: the earliest next issue is cycle 34, once the FSM is back in IDLE.

## Configuration
- Macro: `MULTU_EARLY_EXIT_EN`.
- **Defined**: RUN also exits to DONE after any cycle where the shifted `mplier` becomes zero.
  - Latency = (index of the highest set bit of `op_bE`) + 1 RUN cycles.
  - The minimum is 1 RUN cycle, which occurs when `op_bE` = 0 or 1.
  - The result is bit-identical to the full run.
- **Undefined**: there is always a fixed 32 RUN cycles, and the exit logic is not synthesised.

## Structure
- The shared package `mips_pkg` holds:
  - the `multu_state_t` enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - `WORD_W` = 32
- One sub-module, `multu_step`, is combinational. It takes `acc`, `mcand`, `mplier` and produces the next `acc`, `mcand`, `mplier` and the `mplier_zero` flag.
- The FSM, counter and output registers stay in `multu_seq`.

## Test plan
- **Basic product**: reset, then issue `op_aE`=32'h0000_0003, `op_bE`=32'h0000_0005.
  - `hilo_we` pulses in cycle 33 with `HI_d`=0, `LO_d`=32'h0000_000F.
  - `stall` is high for exactly 33 cycles.
- **Maximum operands**: `op_aE`=`op_bE`=32'hFFFF_FFFF.
  - Expect `HI_d`=32'hFFFF_FFFE, `LO_d`=32'h0000_0001.
- **Flush mid-RUN**: assert `flushE` in cycle 10.
  - The FSM is in IDLE at cycle 11.
  - `hilo_we` never asserts.
  - `HI_d`/`LO_d` keep the prior product.
- **Asynchronous reset**: drop `rst_n` mid-RUN, between clock edges.
  - All outputs are 0 and the state is IDLE before the next edge.
  - A fresh issue afterwards completes correctly.
- **Early exit** (with `MULTU_EARLY_EXIT_EN`):
  - `op_bE`=32'h0000_0010, `op_aE`=32'h1234_5678 gives 5 RUN cycles, `hilo_we` in cycle 6, and `LO_d`=32'h2345_6780, `HI_d`=32'h0000_0001.
  - `op_bE`=0 gives `hilo_we` in cycle 2 with a product of 0.
- **Re-issue while busy**: pulse `multu_enE` again in cycle 5.
  - It is ignored, and the original product completes at cycle 33.
  - A subsequent issue at cycle 34 is accepted.
